// File: rtl/mem_arb_pkg.sv
// Shared types and default sizing for the memory-port arbiter.
// The FSM encoding lives here so the top and any bench see one definition.
package mem_arb_pkg;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_ADDR_WIDTH = 4;
    localparam int DEF_NUM_REQ    = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE_W = 2'd1,
        ISSUE_R = 2'd2,
        WAIT_R  = 2'd3
    } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: search starts one past i_ptr and wraps,
// returning a one-hot grant and its index.
module rr_arbiter #(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     i_req,
    input  logic [IDX_W-1:0] i_ptr,
    output logic [N-1:0]     o_grant,
    output logic [IDX_W-1:0] o_idx
);

    logic             w_found;
    logic [IDX_W-1:0] w_cand;

    always_comb begin
        // NOTE: every output gets a default before the search so no path leaves one unassigned (no latch).
        o_grant = '0;
        o_idx   = '0;
        w_found = 1'b0;
        w_cand  = '0;
        for (int k = 1; k <= N; k++) begin
            w_cand = IDX_W'((int'(i_ptr) + k) % N);
            if (!w_found && i_req[w_cand]) begin
                w_found          = 1'b1;
                o_grant[w_cand]  = 1'b1;
                o_idx            = w_cand;
            end
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port synchronous memory among NUM_REQ requesters with
// round-robin grant; writes pipeline at one per cycle, reads block for three.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int NUM_REQ    = DEF_NUM_REQ
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [NUM_REQ-1:0]             req_we,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]  req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_wdata,
    output logic [NUM_REQ-1:0]             req_ready,
    output logic [NUM_REQ-1:0]             rsp_valid,
    output logic [DATA_WIDTH-1:0]          rsp_rdata,
    output logic                           mem_we,
    output logic                           mem_re,
    output logic [ADDR_WIDTH-1:0]          mem_addr,
    output logic [DATA_WIDTH-1:0]          mem_wdata,
    input  logic [DATA_WIDTH-1:0]          mem_rdata
);

    localparam int IDX_W = $clog2(NUM_REQ);

    state_t r_state;
    state_t w_next_state;

    logic [IDX_W-1:0]      r_last_grant;
    logic [IDX_W-1:0]      r_rd_idx;
    logic [IDX_W-1:0]      w_gnt_idx;
    logic [NUM_REQ-1:0]    w_grant;
    logic                  w_can_accept;
    logic                  w_accept;
    logic                  w_accept_we;
    logic [ADDR_WIDTH-1:0] w_sel_addr;
    logic [DATA_WIDTH-1:0] w_sel_wdata;

    logic                  r_mem_we;
    logic                  r_mem_re;
    logic [ADDR_WIDTH-1:0] r_mem_addr;
    logic [DATA_WIDTH-1:0] r_mem_wdata;
    logic [DATA_WIDTH-1:0] r_rdata_hold;

    rr_arbiter #(
        .N     (NUM_REQ),
        .IDX_W (IDX_W)
    ) u_rr_arbiter (
        .i_req   (req_valid),
        .i_ptr   (r_last_grant),
        .o_grant (w_grant),
        .o_idx   (w_gnt_idx)
    );

    // rst_n gates ready so nothing is offered while reset is held.
    assign w_can_accept = rst_n && (r_state == IDLE || r_state == ISSUE_W);
    assign w_accept     = |req_ready;
    assign w_accept_we  = req_we[w_gnt_idx];
    assign w_sel_addr   = req_addr[int'(w_gnt_idx)*ADDR_WIDTH +: ADDR_WIDTH];
    assign w_sel_wdata  = req_wdata[int'(w_gnt_idx)*DATA_WIDTH +: DATA_WIDTH];

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE, ISSUE_W: begin
                if (w_accept) w_next_state = w_accept_we ? ISSUE_W : ISSUE_R;
                else          w_next_state = IDLE;
            end
            ISSUE_R: w_next_state = WAIT_R;
            WAIT_R:  w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // Memory returns read data the cycle after mem_re, which is WAIT_R.
    always_comb begin
        req_ready = w_can_accept ? w_grant : '0;
        rsp_valid = '0;
        rsp_rdata = r_rdata_hold;
        if (r_state == WAIT_R) begin
            rsp_valid[r_rd_idx] = 1'b1;
            rsp_rdata           = mem_rdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_grant <= IDX_W'(NUM_REQ - 1);
            r_rd_idx     <= '0;
            r_mem_we     <= 1'b0;
            r_mem_re     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_rdata_hold <= '0;
        end else begin
            r_mem_we <= w_accept && w_accept_we;
            r_mem_re <= w_accept && !w_accept_we;
            if (w_accept) begin
                r_last_grant <= w_gnt_idx;
                r_mem_addr   <= w_sel_addr;
                if (w_accept_we) r_mem_wdata <= w_sel_wdata;
                else             r_rd_idx    <= w_gnt_idx;
            end
            if (r_state == WAIT_R) r_rdata_hold <= mem_rdata;
        end
    end

    assign mem_we    = r_mem_we;
    assign mem_re    = r_mem_re;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;

endmodule
